// File: rtl/multigate_demod.sv
// Multi-gate I/Q demodulator. After a programmable number of valid
// samples, it mixes ADC samples against a quarter-rate reference
// (+1, -j, -1, +j). It emits one I/Q sum per gate of SVLength samples,
// for up to NumGates+1 contiguous gates.
module multigate_demod #(
    parameter int ADC_W     = 14,
    parameter int ACC_W     = 32,
    parameter int MAX_GATES = 8
) (
    input  logic                    coreClock,
    input  logic                    RESET,
    input  logic                    ENABLE,
    input  logic                    SAMPLE_VALID,
    input  logic signed [ADC_W-1:0] adcValue,
    input  logic [15:0]             GateDelay,
    input  logic [7:0]              SVLength,
    input  logic [3:0]              NumGates,
    input  logic                    WRITE_READY,
    output logic signed [ACC_W-1:0] IN,
    output logic signed [ACC_W-1:0] QUAD,
    output logic [3:0]              GATE_IDX,
    output logic                    WRITE,
    output logic                    BUSY,
    output logic                    DROPPED
);

    localparam logic [3:0] LAST_GATE_MAX = 4'(MAX_GATES - 1);

    typedef enum logic [1:0] {IDLE, DELAY, ACCUM} state_t;

    state_t                  state;
    logic                    enable_q;
    logic                    start;
    logic [15:0]             delay_cfg;
    logic [15:0]             delay_cnt;
    logic [7:0]              len_cfg;
    logic [7:0]              sample_cnt;
    logic [3:0]              last_gate;
    logic [3:0]              gate_idx;
    logic [1:0]              phase;
    logic signed [ACC_W-1:0] acc_i;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] sample_ext;
    logic signed [ACC_W-1:0] i_next;
    logic signed [ACC_W-1:0] q_next;
    logic                    gate_done;

    // Sign-extend an ADC sample to accumulator width.
    function automatic logic signed [ACC_W-1:0] sext(input logic signed [ADC_W-1:0] x);
        return {{(ACC_W - ADC_W){x[ADC_W-1]}}, x};
    endfunction

    // A zero-length gate would never close, so treat it as one sample.
    function automatic logic [7:0] eff_len(input logic [7:0] n);
        return (n == 8'd0) ? 8'd1 : n;
    endfunction

    // Limit the last gate index to what the instance supports.
    function automatic logic [3:0] clamp_gates(input logic [3:0] n);
        return (n > LAST_GATE_MAX) ? LAST_GATE_MAX : n;
    endfunction

    assign start      = ENABLE & ~enable_q;
    assign sample_ext = sext(adcValue);
    assign gate_done  = (sample_cnt == len_cfg - 8'd1);

    // Mix the current sample into I/Q according to the reference phase.
    always_comb begin
        i_next = acc_i;
        q_next = acc_q;
        case (phase)
            2'd0:    i_next = acc_i + sample_ext;
            2'd1:    q_next = acc_q - sample_ext;
            2'd2:    i_next = acc_i - sample_ext;
            default: q_next = acc_q + sample_ext;
        endcase
    end

    // Acquisition control, accumulation and result registers.
    always_ff @(posedge coreClock or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            enable_q   <= 1'b0;
            delay_cfg  <= '0;
            delay_cnt  <= '0;
            len_cfg    <= 8'd1;
            sample_cnt <= '0;
            last_gate  <= '0;
            gate_idx   <= '0;
            phase      <= '0;
            acc_i      <= '0;
            acc_q      <= '0;
            IN         <= '0;
            QUAD       <= '0;
            GATE_IDX   <= '0;
            WRITE      <= 1'b0;
            BUSY       <= 1'b0;
            DROPPED    <= 1'b0;
        end else begin
            enable_q <= ENABLE;
            WRITE    <= 1'b0;
            // The strobe is never held back; a refused result is only flagged.
            if (WRITE && !WRITE_READY) begin
                DROPPED <= 1'b1;
            end
            case (state)
                IDLE: begin
                    // Stays high for one cycle after the last gate while its WRITE is out.
                    BUSY <= start;
                    if (start) begin
                        delay_cfg  <= GateDelay;
                        delay_cnt  <= '0;
                        len_cfg    <= eff_len(SVLength);
                        last_gate  <= clamp_gates(NumGates);
                        sample_cnt <= '0;
                        gate_idx   <= '0;
                        phase      <= '0;
                        acc_i      <= '0;
                        acc_q      <= '0;
                        DROPPED    <= 1'b0;
                        state      <= (GateDelay == 16'd0) ? ACCUM : DELAY;
                    end
                end
                DELAY: begin
                    if (!ENABLE) begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end else if (SAMPLE_VALID) begin
                        // Phase keeps running so the reference stays tied to the start.
                        phase <= phase + 2'd1;
                        if (delay_cnt == delay_cfg - 16'd1) begin
                            state <= ACCUM;
                        end else begin
                            delay_cnt <= delay_cnt + 16'd1;
                        end
                    end
                end
                ACCUM: begin
                    if (!ENABLE) begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end else if (SAMPLE_VALID) begin
                        phase <= phase + 2'd1;
                        if (gate_done) begin
                            IN         <= i_next;
                            QUAD       <= q_next;
                            GATE_IDX   <= gate_idx;
                            WRITE      <= 1'b1;
                            acc_i      <= '0;
                            acc_q      <= '0;
                            sample_cnt <= '0;
                            gate_idx   <= gate_idx + 4'd1;
                            if (gate_idx == last_gate) begin
                                state <= IDLE;
                            end
                        end else begin
                            acc_i      <= i_next;
                            acc_q      <= q_next;
                            sample_cnt <= sample_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multigate_demod.sv
// Directed and randomized bench for multigate_demod. It uses a reference model
// that computes per-gate I/Q sums from the sample list and the sample index
// since the start.
module tb_multigate_demod;

    localparam int ADC_W     = 14;
    localparam int ACC_W     = 32;
    localparam int MAX_GATES = 8;

    logic                    clk;
    logic                    RESET;
    logic                    ENABLE;
    logic                    SAMPLE_VALID;
    logic signed [ADC_W-1:0] adcValue;
    logic [15:0]             GateDelay;
    logic [7:0]              SVLength;
    logic [3:0]              NumGates;
    logic                    WRITE_READY;
    logic signed [ACC_W-1:0] IN;
    logic signed [ACC_W-1:0] QUAD;
    logic [3:0]              GATE_IDX;
    logic                    WRITE;
    logic                    BUSY;
    logic                    DROPPED;

    int     n_checks = 0;
    int     n_fail   = 0;
    longint in_exp   = 0;
    longint quad_exp = 0;
    int     gidx_exp = 0;
    bit     dropped_exp = 1'b0;
    int     pat[$];

    multigate_demod #(.ADC_W(ADC_W), .ACC_W(ACC_W), .MAX_GATES(MAX_GATES)) dut (
        .coreClock    (clk),
        .RESET        (RESET),
        .ENABLE       (ENABLE),
        .SAMPLE_VALID (SAMPLE_VALID),
        .adcValue     (adcValue),
        .GateDelay    (GateDelay),
        .SVLength     (SVLength),
        .NumGates     (NumGates),
        .WRITE_READY  (WRITE_READY),
        .IN           (IN),
        .QUAD         (QUAD),
        .GATE_IDX     (GATE_IDX),
        .WRITE        (WRITE),
        .BUSY         (BUSY),
        .DROPPED      (DROPPED)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int rand_sample();
        return int'($urandom_range((1 << ADC_W) - 1, 0)) - (1 << (ADC_W - 1));
    endfunction

    // Compare every output against the model state for the cycle just ended.
    task automatic check_cycle(input bit wr_exp, input bit busy_exp);
        chk("write", {63'd0, WRITE}, {63'd0, wr_exp});
        chk("busy", {63'd0, BUSY}, {63'd0, busy_exp});
        chk("in", IN, in_exp);
        chk("quad", QUAD, quad_exp);
        chk("gate_idx", {60'd0, GATE_IDX}, 64'(gidx_exp));
        chk("dropped", {63'd0, DROPPED}, {63'd0, dropped_exp});
    endtask

    // One acquisition: build the sample list, compute the expected gate sums,
    // then drive it cycle by cycle and check the outputs on every falling edge.
    task automatic acquire(input int dly, input int len_in, input int ng_in, input int vpct,
                           input int ready_low_gate, input int abort_at, input bit from_reset);
        int     len, last, total, k, cyc, post, budget, pend_g;
        bit     pending, next_pending, active, v;
        int     smp[$];
        longint ei[16];
        longint eq[16];
        len   = (len_in == 0) ? 1 : len_in;
        last  = (ng_in > MAX_GATES - 1) ? MAX_GATES - 1 : ng_in;
        total = dly + len * (last + 1);
        for (int i = 0; i < total; i++)
            smp.push_back((pat.size() > 0) ? pat[i % pat.size()] : rand_sample());
        for (int g = 0; g < 16; g++) begin
            ei[g] = 0;
            eq[g] = 0;
        end
        // Reference phase is the sample count since start modulo 4: +1, -j, -1, +j.
        for (int i = dly; i < total; i++) begin
            case (i % 4)
                0: ei[(i - dly) / len] += smp[i];
                1: eq[(i - dly) / len] -= smp[i];
                2: ei[(i - dly) / len] -= smp[i];
                default: eq[(i - dly) / len] += smp[i];
            endcase
        end
        pending = 1'b0;
        pend_g  = 0;
        if (!from_reset) begin
            @(negedge clk);
            check_cycle(1'b0, 1'b0);
            ENABLE       = 1'b0;
            SAMPLE_VALID = 1'($urandom_range(1, 0));
        end
        @(negedge clk);
        check_cycle(1'b0, 1'b0);
        GateDelay    = 16'(dly);
        SVLength     = 8'(len_in);
        NumGates     = 4'(ng_in);
        ENABLE       = 1'b1;
        RESET        = 1'b0;
        WRITE_READY  = 1'b1;
        SAMPLE_VALID = 1'($urandom_range(1, 0));
        adcValue     = ADC_W'(rand_sample());
        active       = 1'b1;
        dropped_exp  = 1'b0;
        k      = 0;
        cyc    = 0;
        post   = 0;
        budget = 40 * total + 100;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (pending) begin
                in_exp   = ei[pend_g];
                quad_exp = eq[pend_g];
                gidx_exp = pend_g;
            end
            check_cycle(pending, active || pending);
            WRITE_READY = !(pending && pend_g == ready_low_gate);
            if (pending && pend_g == ready_low_gate) dropped_exp = 1'b1;
            next_pending = 1'b0;
            if (!active && !pending && post >= 3) break;
            if (!active) post++;
            if (cyc > budget) begin
                n_checks++;
                n_fail++;
                $error("FAIL timeout: observed %0d cycles expected at most %0d", cyc, budget);
                break;
            end
            // Configuration is scrambled mid-acquisition; the design must not care.
            GateDelay = 16'($urandom);
            SVLength  = 8'($urandom);
            NumGates  = 4'($urandom);
            if (active && abort_at >= 0 && k == dly + abort_at) begin
                ENABLE       = 1'b0;
                active       = 1'b0;
                SAMPLE_VALID = 1'b1;
                adcValue     = ADC_W'(rand_sample());
            end else if (active) begin
                v = ($urandom_range(99, 0) < vpct);
                SAMPLE_VALID = v;
                adcValue     = ADC_W'(v ? smp[k] : rand_sample());
                if (v) begin
                    if (k >= dly && ((k - dly + 1) % len) == 0) begin
                        next_pending = 1'b1;
                        pend_g       = (k - dly) / len;
                        if (pend_g == last) active = 1'b0;
                    end
                    k++;
                end
            end else begin
                SAMPLE_VALID = 1'($urandom_range(1, 0));
                adcValue     = ADC_W'(rand_sample());
            end
            pending = next_pending;
        end
    endtask

    initial begin
        RESET        = 1'b1;
        ENABLE       = 1'b0;
        SAMPLE_VALID = 1'b0;
        adcValue     = '0;
        GateDelay    = '0;
        SVLength     = '0;
        NumGates     = '0;
        WRITE_READY  = 1'b1;
        repeat (2) @(negedge clk);
        check_cycle(1'b0, 1'b0);
        RESET = 1'b0;

        // Single gate, in-phase tone.
        pat = '{100, 0, -100, 0};
        acquire(0, 4, 0, 100, -1, -1, 1'b0);
        chk("tone_i_in", IN, 64'sd200);
        chk("tone_i_quad", QUAD, 64'sd0);
        chk("tone_i_idx", {60'd0, GATE_IDX}, 64'd0);
        chk("tone_i_busy", {63'd0, BUSY}, 64'd0);

        // Single gate, quadrature tone.
        pat = '{0, -50, 0, 50};
        acquire(0, 4, 0, 100, -1, -1, 1'b0);
        chk("tone_q_in", IN, 64'sd0);
        chk("tone_q_quad", QUAD, 64'sd100);

        // Constant input with delay and three contiguous gates.
        pat = '{10};
        acquire(3, 2, 2, 100, -1, -1, 1'b0);
        chk("const_last_idx", {60'd0, GATE_IDX}, 64'd2);

        // Random samples with gapped SAMPLE_VALID, gate clamp and zero length.
        pat.delete();
        acquire(5, 3, 3, 60, -1, -1, 1'b0);
        acquire(0, 1, 15, 70, -1, -1, 1'b0);
        acquire(2, 0, 1, 50, -1, -1, 1'b0);
        acquire(7, 5, 1, 100, -1, -1, 1'b0);

        // Abort after two accumulated samples, then a clean acquisition.
        acquire(2, 4, 0, 100, -1, 2, 1'b0);
        acquire(2, 4, 0, 80, -1, -1, 1'b0);

        // Downstream refuses gate 1; DROPPED stays set until the next start.
        acquire(1, 3, 2, 100, 1, -1, 1'b0);
        chk("dropped_sticky", {63'd0, DROPPED}, 64'd1);
        acquire(0, 2, 1, 90, -1, -1, 1'b0);

        // Asynchronous reset between clock edges in the middle of a gate.
        @(negedge clk);
        ENABLE = 1'b0;
        @(negedge clk);
        GateDelay    = 16'd0;
        SVLength     = 8'd8;
        NumGates     = 4'd0;
        ENABLE       = 1'b1;
        SAMPLE_VALID = 1'b1;
        adcValue     = ADC_W'(rand_sample());
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 RESET = 1'b1;
        #1;
        in_exp      = 0;
        quad_exp    = 0;
        gidx_exp    = 0;
        dropped_exp = 1'b0;
        check_cycle(1'b0, 1'b0);

        // ENABLE already high at reset release starts single-sample gates.
        acquire(0, 0, 2, 100, -1, -1, 1'b1);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
